ifetch_buffer: RTL and testbench

Parametrised instruction fetch front end that replaces the single-request PC/ROM pairing with a pipelined request/response interface and an instruction FIFO. It issues sequential fetch requests to instruction memory, tolerates variable response latency with multiple requests in flight, buffers returned instructions with their PCs, and supports a single-cycle redirect (branch/jump) that flushes buffered and in-flight fetches. It sits between the instruction memory and the decode stage.

---
 rtl/ifetch_buffer_if.sv | 28 ++
 rtl/ifetch_buffer.sv | 114 +++++++++++
 tb/tb_ifetch_buffer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_buffer_if.sv
// Fetch-unit bus bundle: instruction memory request/response, redirect and decode handshake.
// The master modport is the fetch buffer; the slave modport is the memory/decode environment.
interface ifetch_buffer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ready_i;
  logic              mem_rvalid_i;
  logic [INST_W-1:0] mem_rdata_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              inst_valid_o;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] pc_o;
  logic              inst_ready_i;

  modport master (
    output mem_req_o, mem_addr_o, inst_valid_o, inst_o, pc_o,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i, redirect_i, redirect_pc_i, inst_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, inst_valid_o, inst_o, pc_o,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i, redirect_i, redirect_pc_i, inst_ready_i
  );
endinterface

// File: rtl/ifetch_buffer.sv
// Pipelined instruction fetch front end: sequential requests, in-order responses buffered with
// their PCs in a FIFO, and a single-cycle redirect that flushes buffered and in-flight fetches.
module ifetch_buffer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             rst,
  ifetch_buffer_if.master bus
);

  localparam int unsigned       CntW  = $clog2(DEPTH + 1);
  localparam int unsigned       PtrW  = $clog2(DEPTH);
  localparam int unsigned       SumW  = CntW + 2;
  localparam logic [ADDR_W-1:0] PcInc = ADDR_W'(INST_W / 8);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic [CntW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];

  logic [SumW-1:0] slots_used;
  logic            issue;
  logic            pop;
  logic            push;
  logic            discard;
  logic            resp_tracked;

  // Every slot counts: buffered, live in flight, and in flight but doomed.
  assign slots_used = SumW'(count_q) + SumW'(outstanding_q) + SumW'(drop_cnt_q);

  assign bus.mem_req_o    = !rst && !bus.redirect_i && (slots_used < SumW'(DEPTH));
  assign bus.mem_addr_o   = fetch_pc_q;
  assign bus.inst_valid_o = (count_q != '0) && !bus.redirect_i;
  assign bus.inst_o       = inst_mem_q[rd_ptr_q];
  assign bus.pc_o         = pc_mem_q[rd_ptr_q];

  assign issue        = bus.mem_req_o && bus.mem_ready_i;
  assign pop          = bus.inst_valid_o && bus.inst_ready_i;
  assign discard      = bus.mem_rvalid_i && (drop_cnt_q != '0);
  assign push         = bus.mem_rvalid_i && (drop_cnt_q == '0) && (outstanding_q != '0) &&
                        !bus.redirect_i;
  assign resp_tracked = bus.mem_rvalid_i && ((drop_cnt_q != '0) || (outstanding_q != '0));

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (bus.redirect_i) begin
      fetch_pc_d    = bus.redirect_pc_i;
      resp_pc_d     = bus.redirect_pc_i;
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      outstanding_d = '0;
      // Live fetches become doomed; a response landing this cycle retires one of them.
      drop_cnt_d    = drop_cnt_q + outstanding_q - CntW'(resp_tracked);
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + PcInc;
      end
      if (push) begin
        resp_pc_d = resp_pc_q + PcInc;
        wr_ptr_d  = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d       = count_q + CntW'(push) - CntW'(pop);
      outstanding_d = outstanding_q + CntW'(issue) - CntW'(push);
      drop_cnt_d    = drop_cnt_q - CntW'(discard);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= resp_pc_q;
        inst_mem_q[wr_ptr_q] <= bus.mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer: an in-order latency memory, a queue-based model of
// buffered and in-flight fetches checked every cycle, plus hand-computed literal checks.
module tb_ifetch_buffer;
  localparam int unsigned AW       = 32;
  localparam int unsigned IW       = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifetch_buffer_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

  ifetch_buffer #(
    .ADDR_W  (AW),
    .INST_W  (IW),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int lat     = 1;
  int last_due = -1;
  int req_cnt = 0;

  // Memory: accepted requests with the cycle their response is due.
  int          mq_due[$];
  logic [31:0] mq_addr[$];

  // Model: decode-visible FIFO, in-flight PCs (oldest m_dead of them are doomed), fetch PC.
  logic [31:0] m_fifo_pc[$];
  logic [31:0] m_fifo_inst[$];
  logic [31:0] m_infl[$];
  int          m_dead = 0;
  logic [31:0] m_fpc = RESET_PC;

  function automatic logic [31:0] mem_data(logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic step();
    bit          e_req, e_valid;
    logic [31:0] a;
    int          d;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = mem_data(mq_addr[0]);
      void'(mq_due.pop_front());
      void'(mq_addr.pop_front());
    end else begin
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = 32'h0;
    end
    @(negedge clk);
    e_req   = !rst && !bus.redirect_i && (m_fifo_pc.size() + m_infl.size() < int'(DEPTH));
    e_valid = !rst && !bus.redirect_i && (m_fifo_pc.size() > 0);
    chk("mem_req_o", 32'(bus.mem_req_o), 32'(e_req));
    if (e_req) chk("mem_addr_o", bus.mem_addr_o, m_fpc);
    chk("inst_valid_o", 32'(bus.inst_valid_o), 32'(e_valid));
    if (e_valid) begin
      chk("pc_o", bus.pc_o, m_fifo_pc[0]);
      chk("inst_o", bus.inst_o, m_fifo_inst[0]);
    end
    if (rst) begin
      chk("rst_inst_o", bus.inst_o, 32'h0);
      chk("rst_pc_o", bus.pc_o, 32'h0);
    end
    if (bus.mem_req_o && bus.mem_ready_i) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      mq_due.push_back(d);
      mq_addr.push_back(bus.mem_addr_o);
      last_due = d;
      req_cnt++;
    end
    if (rst) begin
      m_fifo_pc.delete();
      m_fifo_inst.delete();
      m_infl.delete();
      m_dead = 0;
      m_fpc  = RESET_PC;
    end else if (bus.redirect_i) begin
      m_fifo_pc.delete();
      m_fifo_inst.delete();
      m_dead = m_infl.size();
      if (bus.mem_rvalid_i && m_infl.size() > 0) begin
        void'(m_infl.pop_front());
        m_dead--;
      end
      m_fpc = bus.redirect_pc_i;
    end else begin
      if (e_valid && bus.inst_ready_i) begin
        void'(m_fifo_pc.pop_front());
        void'(m_fifo_inst.pop_front());
      end
      if (bus.mem_rvalid_i && m_infl.size() > 0) begin
        a = m_infl.pop_front();
        if (m_dead > 0) m_dead--;
        else begin
          m_fifo_pc.push_back(a);
          m_fifo_inst.push_back(mem_data(a));
        end
      end
      if (e_req && bus.mem_ready_i) begin
        m_infl.push_back(m_fpc);
        m_fpc = m_fpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reset while draining any responses the memory still owes, so tests start clean.
  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready_i  = 1'b0;
    bus.redirect_i   = 1'b0;
    bus.inst_ready_i = 1'b0;
    step();
    step();
    for (int i = 0; i < 20 && mq_due.size() > 0; i++) step();
    rst = 1'b0;
    req_cnt = 0;
    #1;
  endtask

  task automatic wait_valid(int max_cycles, string name);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      if (bus.inst_valid_o) seen = 1'b1;
      else step();
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    bus.mem_ready_i   = 1'b0;
    bus.mem_rvalid_i  = 1'b0;
    bus.mem_rdata_i   = 32'h0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.inst_ready_i  = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_mem_req", 32'(bus.mem_req_o), 32'd0);
    chk("reset_inst_valid", 32'(bus.inst_valid_o), 32'd0);
    chk("reset_inst_o", bus.inst_o, 32'h0);
    chk("reset_pc_o", bus.pc_o, 32'h0);
    step();
    step();

    // Streaming with a 1-cycle memory
    lat = 1;
    bus.mem_ready_i  = 1'b1;
    bus.inst_ready_i = 1'b1;
    rst = 1'b0;
    #1;
    chk("t1_req_cycle0", 32'(bus.mem_req_o), 32'd1);
    chk("t1_addr0", bus.mem_addr_o, 32'h0);
    step();
    chk("t1_addr4", bus.mem_addr_o, 32'h4);
    step();
    chk("t1_valid_cycle2", 32'(bus.inst_valid_o), 32'd1);
    chk("t1_pc0", bus.pc_o, 32'h0);
    chk("t1_inst0", bus.inst_o, 32'hDEAD_BEEF);
    step();
    chk("t1_pc4", bus.pc_o, 32'h4);
    repeat (8) step();
    chk("t1_no_gap", 32'(bus.inst_valid_o), 32'd1);

    // Backpressure fills the FIFO, then releases in order
    do_reset();
    lat = 1;
    bus.mem_ready_i = 1'b1;
    repeat (8) step();
    chk("t2_req_stalled", 32'(bus.mem_req_o), 32'd0);
    chk("t2_req_count", 32'(req_cnt), 32'd4);
    chk("t2_head_pc", bus.pc_o, 32'h0);
    bus.inst_ready_i = 1'b1;
    step();
    chk("t2_resume_req", 32'(bus.mem_req_o), 32'd1);
    chk("t2_resume_addr", bus.mem_addr_o, 32'h10);
    chk("t2_second_pc", bus.pc_o, 32'h4);
    repeat (8) step();

    // Redirect with three live fetches in flight
    do_reset();
    lat = 4;
    bus.mem_ready_i  = 1'b1;
    bus.inst_ready_i = 1'b1;
    repeat (3) step();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h100;
    #1;
    chk("t3_redirect_blocks_req", 32'(bus.mem_req_o), 32'd0);
    step();
    bus.redirect_i = 1'b0;
    #1;
    chk("t3_req_target", bus.mem_addr_o, 32'h100);
    wait_valid(20, "t3_wait_valid");
    chk("t3_first_pc", bus.pc_o, 32'h100);
    chk("t3_first_inst", bus.inst_o, mem_data(32'h100));
    repeat (4) step();

    // Back-to-back redirects
    do_reset();
    lat = 2;
    bus.mem_ready_i  = 1'b1;
    bus.inst_ready_i = 1'b1;
    repeat (2) step();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h200;
    step();
    bus.redirect_pc_i = 32'h300;
    step();
    bus.redirect_i = 1'b0;
    #1;
    wait_valid(20, "t4_wait_valid");
    chk("t4_first_pc", bus.pc_o, 32'h300);
    repeat (4) step();

    // Address wrap at the top of the address space
    do_reset();
    lat = 1;
    bus.mem_ready_i   = 1'b1;
    bus.inst_ready_i  = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFF8;
    step();
    bus.redirect_i = 1'b0;
    #1;
    chk("t5_addr_f8", bus.mem_addr_o, 32'hFFFF_FFF8);
    step();
    chk("t5_addr_fc", bus.mem_addr_o, 32'hFFFF_FFFC);
    step();
    chk("t5_addr_wrap", bus.mem_addr_o, 32'h0);
    chk("t5_pc_f8", bus.pc_o, 32'hFFFF_FFF8);
    step();
    chk("t5_pc_fc", bus.pc_o, 32'hFFFF_FFFC);
    step();
    chk("t5_pc_wrap", bus.pc_o, 32'h0);
    chk("t5_inst_wrap", bus.inst_o, mem_data(32'h0));
    repeat (3) step();

    // Reset mid-stream with a full FIFO and slow responses still owed
    do_reset();
    lat = 1;
    bus.mem_ready_i = 1'b1;
    repeat (7) step();
    chk("t6_full_head", bus.pc_o, 32'h0);
    lat = 6;
    bus.inst_ready_i = 1'b1;
    repeat (2) step();
    bus.inst_ready_i = 1'b0;
    repeat (2) step();
    chk("t6_full_no_req", 32'(bus.mem_req_o), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_rst_req", 32'(bus.mem_req_o), 32'd0);
    chk("t6_rst_valid", 32'(bus.inst_valid_o), 32'd0);
    chk("t6_rst_inst", bus.inst_o, 32'h0);
    chk("t6_rst_pc", bus.pc_o, 32'h0);
    step();
    step();
    rst = 1'b0;
    bus.mem_ready_i = 1'b0;
    for (int i = 0; i < 20 && mq_due.size() > 0; i++) step();
    step();
    chk("t6_late_drained", 32'(mq_due.size()), 32'd0);
    chk("t6_late_ignored", 32'(bus.inst_valid_o), 32'd0);
    bus.mem_ready_i  = 1'b1;
    bus.inst_ready_i = 1'b1;
    lat = 1;
    #1;
    chk("t6_restart_req", 32'(bus.mem_req_o), 32'd1);
    chk("t6_restart_addr", bus.mem_addr_o, RESET_PC);
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
